// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU control codes, operand-B
// select encodings, mul/div FSM states and EX/WB control bus field positions.
package ex_pkg;

  localparam int EX_XLEN     = 32;
  localparam int EX_MD_ITERS = 32;

  // aluctrl codes
  localparam logic [5:0] ALU_ADD   = 6'd0;
  localparam logic [5:0] ALU_SUB   = 6'd1;
  localparam logic [5:0] ALU_AND   = 6'd2;
  localparam logic [5:0] ALU_OR    = 6'd3;
  localparam logic [5:0] ALU_XOR   = 6'd4;
  localparam logic [5:0] ALU_NOR   = 6'd5;
  localparam logic [5:0] ALU_SLT   = 6'd6;
  localparam logic [5:0] ALU_SLTU  = 6'd7;
  localparam logic [5:0] ALU_SLL   = 6'd8;
  localparam logic [5:0] ALU_SRL   = 6'd9;
  localparam logic [5:0] ALU_SRA   = 6'd10;
  localparam logic [5:0] ALU_LUI   = 6'd11;
  localparam logic [5:0] ALU_MFHI  = 6'd12;
  localparam logic [5:0] ALU_MFLO  = 6'd13;
  localparam logic [5:0] ALU_MULT  = 6'd16;
  localparam logic [5:0] ALU_MULTU = 6'd17;
  localparam logic [5:0] ALU_DIV   = 6'd18;
  localparam logic [5:0] ALU_DIVU  = 6'd19;

  // aluSrc encodings for operand B
  localparam logic [1:0] SRC_RT    = 2'b00;
  localparam logic [1:0] SRC_IMM   = 2'b01;
  localparam logic [1:0] SRC_SHAMT = 2'b10;
  localparam logic [1:0] SRC_RT2   = 2'b11;

  // EX control bus fields
  localparam int EX_ALUCTRL_LSB = 0;
  localparam int EX_ALUCTRL_MSB = 5;
  localparam int EX_ALUSRC_LSB  = 6;
  localparam int EX_ALUSRC_MSB  = 7;
  localparam int EX_NODEST      = 8;
  localparam int EX_REGDST      = 9;

  // WB control bus fields
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [5:0] code);
    return (code >= ALU_MULT) && (code <= ALU_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: captures operand magnitudes, runs one
// shift-add or restoring-subtract step per cycle, then applies sign fixup.
//
// Handshake: start_i is sampled only in IDLE and launches an operation;
// done_o is high for exactly the one DONE cycle, during which hi_o/lo_o hold
// the final result. abort_i returns the unit to IDLE from any state.
module muldiv_iter import ex_pkg::*; #(
  parameter int XLEN     = EX_XLEN,
  parameter int MD_ITERS = EX_MD_ITERS
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [5:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output md_state_e       state_o
);

  localparam int CW = $clog2(MD_ITERS);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;    // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic              is_div_q, is_div_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              b_zero_q, b_zero_d;

  logic              op_signed;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] prod;

  assign op_signed = (op_i == ALU_MULT) || (op_i == ALU_DIV);

  // One iteration step of each algorithm, from the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt   = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    if (div_diff[XLEN+1]) begin
      div_nxt = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
  end

  // FSM next state, operand capture and iteration control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    b_zero_d = b_zero_q;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          neg_a_d  = op_signed & a_i[XLEN-1];
          neg_b_d  = op_signed & b_i[XLEN-1];
          is_div_d = (op_i == ALU_DIV) || (op_i == ALU_DIVU);
          b_zero_d = (b_i == '0);
          acc_d    = {{XLEN{1'b0}}, (op_signed & a_i[XLEN-1]) ? -a_i : a_i};
          opnd_d   = (op_signed & b_i[XLEN-1]) ? -b_i : b_i;
          cnt_d    = CW'(MD_ITERS - 1);
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        acc_d = is_div_q ? div_nxt : mul_nxt;
        if (cnt_q == '0) begin
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    if (abort_i) begin
      state_d = MD_IDLE;
    end
  end

  // Sign fixup of the unsigned magnitude result.
  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    hi_o = prod[2*XLEN-1:XLEN];
    lo_o = prod[XLEN-1:0];
    if (is_div_q) begin
      hi_o = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (b_zero_q) begin
        lo_o = '1;
      end else begin
        lo_o = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      end
    end
  end

  assign done_o  = (state_q == MD_DONE);
  assign state_o = state_q;

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      b_zero_q <= b_zero_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_stage.sv
// Execute stage: single-cycle ALU, operand/destination muxes, HI/LO registers,
// EX/MEM pipeline register and the stall request while mul/div is running.
module ex_muldiv_stage import ex_pkg::*; #(
  parameter int XLEN     = EX_XLEN,
  parameter int MD_ITERS = EX_MD_ITERS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic [1:0]      WB,
  input  logic [2:0]      M,
  input  logic [9:0]      EX,
  input  logic [XLEN-1:0] regRs,
  input  logic [XLEN-1:0] regRt,
  input  logic [XLEN-1:0] imm_value,
  input  logic [XLEN-1:0] PC,
  input  logic [4:0]      addrRt,
  input  logic [4:0]      addrRd,
  output logic            stall,
  output logic [1:0]      WBOut,
  output logic [2:0]      MOut,
  output logic [XLEN-1:0] aluResultOut,
  output logic [XLEN-1:0] storeDataOut,
  output logic [4:0]      addrDestOut,
  output logic [XLEN-1:0] PCOut
);

  localparam int SHW = $clog2(XLEN);

  logic [5:0]      aluctrl;
  logic [1:0]      alu_src;
  logic            no_dest;
  logic            is_md;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;

  md_state_e       md_state;
  logic            md_start;
  logic            md_done;
  logic [XLEN-1:0] md_hi, md_lo;

  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [1:0]      wb_q, wb_d;
  logic [2:0]      m_q, m_d;
  logic [XLEN-1:0] res_q, res_d, sd_q, sd_d, pc_q, pc_d;
  logic [4:0]      dest_q, dest_d;

  assign aluctrl = EX[EX_ALUCTRL_MSB:EX_ALUCTRL_LSB];
  assign alu_src = EX[EX_ALUSRC_MSB:EX_ALUSRC_LSB];
  assign no_dest = EX[EX_NODEST];
  assign is_md   = is_muldiv(aluctrl);

  // Only a fresh mul/div in IDLE, or an iteration in BUSY, holds the pipe.
  assign md_start = (md_state == MD_IDLE) & is_md & ~flush;
  assign stall    = ~reset & ~flush & (((md_state == MD_IDLE) & is_md) | (md_state == MD_BUSY));

  muldiv_iter #(.XLEN(XLEN), .MD_ITERS(MD_ITERS)) u_muldiv (
    .clk_i   (clock),
    .rst_i   (reset),
    .start_i (md_start),
    .abort_i (flush),
    .op_i    (aluctrl),
    .a_i     (regRs),
    .b_i     (regRt),
    .done_o  (md_done),
    .hi_o    (md_hi),
    .lo_o    (md_lo),
    .state_o (md_state)
  );

  // Operand B select and single-cycle ALU.
  always_comb begin
    case (alu_src)
      SRC_IMM:         op_b = imm_value;
      SRC_SHAMT:       op_b = {{(XLEN-5){1'b0}}, imm_value[10:6]};
      SRC_RT, SRC_RT2: op_b = regRt;
      default:         op_b = regRt;
    endcase
    shamt = op_b[SHW-1:0];
    case (aluctrl)
      ALU_ADD:  alu_res = regRs + op_b;
      ALU_SUB:  alu_res = regRs - op_b;
      ALU_AND:  alu_res = regRs & op_b;
      ALU_OR:   alu_res = regRs | op_b;
      ALU_XOR:  alu_res = regRs ^ op_b;
      ALU_NOR:  alu_res = ~(regRs | op_b);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(regRs) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, regRs < op_b};
      ALU_SLL:  alu_res = regRs << shamt;
      ALU_SRL:  alu_res = regRs >> shamt;
      ALU_SRA:  alu_res = $signed(regRs) >>> shamt;
      ALU_LUI:  alu_res = {op_b[XLEN/2-1:0], {(XLEN/2){1'b0}}};
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  // EX/MEM next value: bubble unless a single-cycle op issues or mul/div completes.
  always_comb begin
    wb_d   = '0;
    m_d    = '0;
    res_d  = '0;
    sd_d   = '0;
    dest_d = '0;
    pc_d   = '0;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (!flush && (md_done || ((md_state == MD_IDLE) && !is_md))) begin
      wb_d   = {WB[WB_MEMTOREG], WB[WB_REGWRITE] & ~no_dest};
      m_d    = M;
      res_d  = md_done ? md_lo : alu_res;
      sd_d   = regRt;
      dest_d = no_dest ? 5'd0 : (EX[EX_REGDST] ? addrRd : addrRt);
      pc_d   = PC;
      if (md_done) begin
        hi_d = md_hi;
        lo_d = md_lo;
      end
    end
  end

  // EX/MEM pipeline register and HI/LO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_q   <= '0;
      m_q    <= '0;
      res_q  <= '0;
      sd_q   <= '0;
      dest_q <= '0;
      pc_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      wb_q   <= wb_d;
      m_q    <= m_d;
      res_q  <= res_d;
      sd_q   <= sd_d;
      dest_q <= dest_d;
      pc_q   <= pc_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign WBOut        = wb_q;
  assign MOut         = m_q;
  assign aluResultOut = res_q;
  assign storeDataOut = sd_q;
  assign addrDestOut  = dest_q;
  assign PCOut        = pc_q;

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Bench for ex_muldiv_stage: directed instruction stream, an instruction-level
// model producing per-cycle expected {stall, EX/MEM} entries, and literal pins.
module tb_ex_muldiv_stage;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [5:0]  op;
    logic [1:0]  src;
    logic        nd;
    logic        rdst;
    logic [31:0] rs, rt, imm, pc;
    logic [4:0]  art, ard;
  } instr_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clock = 1'b0;
  logic        reset, flush;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic [9:0]  EX;
  logic [31:0] regRs, regRt, imm_value, PC;
  logic [4:0]  addrRt, addrRd;
  logic        stall;
  logic [1:0]  WBOut;
  logic [2:0]  MOut;
  logic [31:0] aluResultOut, storeDataOut, PCOut;
  logic [4:0]  addrDestOut;

  always #5 clock = ~clock;

  ex_muldiv_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .WB(WB), .M(M), .EX(EX),
    .regRs(regRs), .regRt(regRt), .imm_value(imm_value), .PC(PC),
    .addrRt(addrRt), .addrRd(addrRd),
    .stall(stall), .WBOut(WBOut), .MOut(MOut),
    .aluResultOut(aluResultOut), .storeDataOut(storeDataOut),
    .addrDestOut(addrDestOut), .PCOut(PCOut)
  );

  // ---------------- scoreboard state ----------------
  logic [106:0] exp_q[$];          // {stall, WB, M, result, store, dest, PC}
  logic [105:0] cur_exp, nxt_exp;  // EX/MEM now / after the coming edge
  logic [106:0] cmp_e;
  logic [31:0]  m_hi, m_lo;
  int           vectors = 0;
  int           miscompares = 0;
  string        tname = "reset";
  logic         lit_en;
  string        lit_name;
  logic [31:0]  lit_val;
  int           stall_run = 0;
  int           last_run = 0;

  wire [105:0] act_out = {WBOut, MOut, aluResultOut, storeDataOut, addrDestOut, PCOut};

  // ---------------- model ----------------
  function automatic instr_t mk(input logic [1:0] wb, input logic [2:0] m, input logic [5:0] op,
                                input logic [1:0] src, input logic nd, input logic rdst,
                                input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [4:0] art, input logic [4:0] ard);
    instr_t t;
    t.wb = wb; t.m = m; t.op = op; t.src = src; t.nd = nd; t.rdst = rdst;
    t.rs = rs; t.rt = rt; t.imm = imm; t.pc = pc; t.art = art; t.ard = ard;
    return t;
  endfunction

  function automatic logic [31:0] b_of(input instr_t t);
    if (t.src == 2'b01) return t.imm;
    if (t.src == 2'b10) return {27'b0, t.imm[10:6]};
    return t.rt;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      6'd0:  return a + b;
      6'd1:  return a - b;
      6'd2:  return a & b;
      6'd3:  return a | b;
      6'd4:  return a ^ b;
      6'd5:  return ~(a | b);
      6'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd7:  return (a < b) ? 32'd1 : 32'd0;
      6'd8:  return a << b[4:0];
      6'd9:  return a >> b[4:0];
      6'd10: return $signed(a) >>> b[4:0];
      6'd11: return {b[15:0], 16'h0000};
      6'd12: return m_hi;
      6'd13: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] md_ref(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] p;
    p = 64'd0;
    x = $signed(a);
    y = $signed(b);
    case (op)
      6'd16: p = x * y;
      6'd17: p = {32'b0, a} * {32'b0, b};
      6'd18: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else begin q = x / y; r = x % y; p = {r[31:0], q[31:0]}; end
      end
      6'd19: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  function automatic logic [105:0] pack(input instr_t t, input logic [31:0] res);
    logic [4:0] dest;
    dest = t.nd ? 5'd0 : (t.rdst ? t.ard : t.art);
    return {t.wb[1], t.wb[0] & ~t.nd, t.m, res, t.rt, dest, t.pc};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      vectors++;
      if ({stall, act_out} !== cmp_e) begin
        miscompares++;
        $display("FAIL %s exmem: got stall=%b out=%h, expected stall=%b out=%h",
                 tname, stall, act_out, cmp_e[106], cmp_e[105:0]);
      end
    end
  end

  // Length of the most recent run of consecutive stall cycles.
  always @(negedge clock) begin
    if (stall === 1'b1) stall_run++;
    else begin
      if (stall_run != 0) last_run = stall_run;
      stall_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic expect_lit(input string name, input logic [31:0] v);
    lit_en = 1'b1; lit_name = name; lit_val = v;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    cur_exp = nxt_exp;
    if (lit_en) begin
      check(lit_name, aluResultOut, lit_val);
      lit_en = 1'b0;
    end
  endtask

  task automatic drive(input instr_t t);
    flush = 1'b0;
    WB = t.wb; M = t.m; EX = {t.rdst, t.nd, t.src, t.op};
    regRs = t.rs; regRt = t.rt; imm_value = t.imm; PC = t.pc;
    addrRt = t.art; addrRd = t.ard;
  endtask

  task automatic single_op(input string name, input instr_t t);
    next_cycle();
    tname = name;
    drive(t);
    exp_q.push_back({1'b0, cur_exp});
    nxt_exp = pack(t, alu_ref(t.op, t.rs, b_of(t)));
  endtask

  task automatic md_op(input string name, input instr_t t, input int flush_at, input int reset_at);
    logic [63:0] r;
    instr_t nop;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    r = md_ref(t.op, t.rs, t.rt);
    for (int c = 0; c < 34; c++) begin
      next_cycle();
      tname = name;
      drive(t);
      if (c == flush_at) begin
        flush = 1'b1;
        exp_q.push_back({1'b0, cur_exp});
        nxt_exp = '0;
        break;
      end else if (c == reset_at) begin
        exp_q.push_back({1'b1, cur_exp});
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_result", aluResultOut, 32'd0);
        check("rst_store", storeDataOut, 32'd0);
        check("rst_pc", PCOut, 32'd0);
        check("rst_ctl", {22'b0, WBOut, MOut, addrDestOut}, 32'd0);
        drive(nop);
        m_hi = 32'd0; m_lo = 32'd0;
        nxt_exp = '0;
        next_cycle();
        exp_q.push_back({1'b0, cur_exp});
        next_cycle();
        reset = 1'b0;
        exp_q.push_back({1'b0, cur_exp});
        nxt_exp = pack(nop, 32'd0);
        break;
      end else if (c < 33) begin
        exp_q.push_back({1'b1, cur_exp});
        nxt_exp = '0;
      end else begin
        exp_q.push_back({1'b0, cur_exp});
        nxt_exp = pack(t, r[31:0]);
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
    end
  endtask

  // ---------------- stimulus ----------------
  localparam logic [5:0] MFHI = 6'd12, MFLO = 6'd13;
  instr_t nop_i, mfhi_i, mflo_i;

  initial begin
    nop_i  = mk(2'b00, 3'b000, 6'd0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    mfhi_i = mk(2'b01, 3'b000, MFHI, 2'b00, 0, 1, 0, 0, 0, 32'h300, 0, 5'd8);
    mflo_i = mk(2'b01, 3'b000, MFLO, 2'b00, 0, 1, 0, 0, 0, 32'h304, 0, 5'd9);
    reset = 1'b1; flush = 1'b0; lit_en = 1'b0;
    drive(nop_i);
    cur_exp = '0; nxt_exp = '0; m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_result", aluResultOut, 32'd0);
    check("reset_store", storeDataOut, 32'd0);
    check("reset_pc", PCOut, 32'd0);
    check("reset_ctl", {22'b0, WBOut, MOut, addrDestOut}, 32'd0);
    reset = 1'b0;

    // single-cycle ALU ops
    single_op("add", mk(2'b01, 3'b000, 6'd0, 2'b01, 0, 0, 32'd7, 32'h55, 32'hFFFFFFFD, 32'h100, 5'd9, 5'd3));
    expect_lit("add_result", 32'd4);
    single_op("lw", mk(2'b11, 3'b001, 6'd0, 2'b01, 0, 0, 32'h1000, 32'hAA, 32'h10, 32'h104, 5'd4, 5'd0));
    expect_lit("lw_addr", 32'h1010);
    single_op("sub", mk(2'b01, 3'b000, 6'd1, 2'b00, 0, 1, 32'd5, 32'd9, 0, 32'h108, 5'd1, 5'd2));
    expect_lit("sub_result", 32'hFFFFFFFC);
    single_op("and", mk(2'b01, 3'b000, 6'd2, 2'b00, 0, 1, 32'hF0F0, 32'hFF00, 0, 32'h10C, 5'd1, 5'd5));
    single_op("or",  mk(2'b01, 3'b000, 6'd3, 2'b00, 0, 1, 32'hF0F0, 32'hFF00, 0, 32'h110, 5'd1, 5'd6));
    single_op("xor", mk(2'b01, 3'b000, 6'd4, 2'b00, 0, 1, 32'hF0F0, 32'hFF00, 0, 32'h114, 5'd1, 5'd7));
    single_op("nor", mk(2'b01, 3'b000, 6'd5, 2'b00, 0, 1, 32'hF0F0, 32'hFF00, 0, 32'h118, 5'd1, 5'd8));
    single_op("slt", mk(2'b01, 3'b000, 6'd6, 2'b00, 0, 1, 32'hFFFFFFFF, 32'd1, 0, 32'h11C, 5'd1, 5'd9));
    expect_lit("slt_result", 32'd1);
    single_op("sltu", mk(2'b01, 3'b000, 6'd7, 2'b00, 0, 1, 32'hFFFFFFFF, 32'd1, 0, 32'h120, 5'd1, 5'd10));
    expect_lit("sltu_result", 32'd0);
    single_op("sll", mk(2'b01, 3'b000, 6'd8, 2'b10, 0, 1, 32'd1, 32'd0, 32'h0C0, 32'h124, 5'd1, 5'd11));
    expect_lit("sll_result", 32'd8);
    single_op("srl", mk(2'b01, 3'b000, 6'd9, 2'b00, 0, 1, 32'h80000000, 32'd31, 0, 32'h128, 5'd1, 5'd12));
    single_op("lui", mk(2'b01, 3'b000, 6'd11, 2'b01, 0, 0, 32'd0, 32'd0, 32'h1234, 32'h12C, 5'd13, 5'd1));
    expect_lit("lui_result", 32'h12340000);
    single_op("undef", mk(2'b01, 3'b010, 6'd14, 2'b00, 0, 0, 32'd5, 32'd5, 0, 32'h130, 5'd14, 5'd1));
    single_op("src11", mk(2'b01, 3'b000, 6'd0, 2'b11, 0, 0, 32'd1, 32'd2, 32'd100, 32'h134, 5'd15, 5'd1));
    expect_lit("src11_result", 32'd3);
    single_op("sra", mk(2'b01, 3'b000, 6'd10, 2'b10, 1, 1, 32'h80000000, 32'h80000000, 32'h100, 32'h138, 5'd16, 5'd17));
    expect_lit("sra_result", 32'hF8000000);

    // multiply / divide with HI/LO readback
    md_op("mult", mk(2'b00, 3'b000, 6'd16, 2'b00, 1, 0, 32'hFFFFFFFA, 32'd7, 0, 32'h200, 0, 0), -1, -1);
    @(negedge clock);
    #1;
    check("mult_stall_cycles", 32'(last_run), 32'd33);
    check("model_mult_hi", m_hi, 32'hFFFFFFFF);
    check("model_mult_lo", m_lo, 32'hFFFFFFD6);
    expect_lit("mult_lo", 32'hFFFFFFD6);
    single_op("mfhi", mfhi_i);
    expect_lit("mfhi_mult", 32'hFFFFFFFF);
    single_op("mflo", mflo_i);
    expect_lit("mflo_mult", 32'hFFFFFFD6);

    md_op("div", mk(2'b00, 3'b000, 6'd18, 2'b00, 1, 0, 32'hFFFFFFF9, 32'd2, 0, 32'h210, 0, 0), -1, -1);
    check("model_div_lo", m_lo, 32'hFFFFFFFD);
    expect_lit("div_lo", 32'hFFFFFFFD);
    single_op("mfhi", mfhi_i);
    expect_lit("div_hi", 32'hFFFFFFFF);
    md_op("divu0", mk(2'b00, 3'b000, 6'd19, 2'b00, 1, 0, 32'd100, 32'd0, 0, 32'h220, 0, 0), -1, -1);
    expect_lit("divu0_lo", 32'hFFFFFFFF);
    single_op("mfhi", mfhi_i);
    expect_lit("divu0_hi", 32'd100);
    md_op("div0", mk(2'b00, 3'b000, 6'd18, 2'b00, 1, 0, 32'hFFFFFFFB, 32'd0, 0, 32'h230, 0, 0), -1, -1);
    expect_lit("div0_lo", 32'hFFFFFFFF);
    single_op("mfhi", mfhi_i);
    expect_lit("div0_hi", 32'hFFFFFFFB);
    md_op("divovf", mk(2'b00, 3'b000, 6'd18, 2'b00, 1, 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h240, 0, 0), -1, -1);
    expect_lit("divovf_lo", 32'h80000000);
    single_op("mfhi", mfhi_i);
    expect_lit("divovf_hi", 32'd0);
    md_op("multu", mk(2'b00, 3'b000, 6'd17, 2'b00, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h250, 0, 0), -1, -1);
    expect_lit("multu_lo", 32'h00000001);
    single_op("mfhi", mfhi_i);
    expect_lit("multu_hi", 32'hFFFFFFFE);

    // flush in the 10th busy cycle of a MULTU
    md_op("multu_flush", mk(2'b00, 3'b000, 6'd17, 2'b00, 1, 0, 32'h1234, 32'h5678, 0, 32'h260, 0, 0), 10, -1);
    expect_lit("flush_bubble", 32'd0);
    single_op("mfhi", mfhi_i);
    expect_lit("flush_hi_kept", 32'hFFFFFFFE);
    single_op("mflo", mflo_i);
    expect_lit("flush_lo_kept", 32'h00000001);
    single_op("add2", mk(2'b01, 3'b000, 6'd0, 2'b00, 0, 1, 32'd10, 32'd20, 0, 32'h270, 5'd1, 5'd20));
    expect_lit("add2_result", 32'd30);

    // reset in the middle of a DIV, then a fresh DIV
    md_op("div_rst", mk(2'b00, 3'b000, 6'd18, 2'b00, 1, 0, 32'd1000, 32'd3, 0, 32'h280, 0, 0), -1, 15);
    single_op("mfhi", mfhi_i);
    expect_lit("rst_hi", 32'd0);
    single_op("mflo", mflo_i);
    expect_lit("rst_lo", 32'd0);
    md_op("div2", mk(2'b00, 3'b000, 6'd18, 2'b00, 1, 0, 32'd100, 32'hFFFFFFF9, 0, 32'h290, 0, 0), -1, -1);
    expect_lit("div2_lo", 32'hFFFFFFF2);
    single_op("mfhi", mfhi_i);
    expect_lit("div2_hi", 32'd2);
    single_op("nop", nop_i);
    single_op("nop", nop_i);

    repeat (3) @(posedge clock);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
